npcg_toggle_bnc_mp_erase: RTL and testbench

- Multi-plane block-erase command generator for the Toggle NAND channel BNC layer.
- Accepts one erase command from the way dispatcher and erases 1..MaxPlanes planes of one target way.
- Per plane: drives the primitive manager (PM) with one CAL burst (60h, row address, D1h/D0h), then one timer.
- Optional 27h erase-resume preset and A2h/FAh prefix are issued before plane 0.

---
 rtl/npcg_toggle_bnc_mp_erase.sv | 201 ++++++++++++++++++++
 tb/tb_npcg_toggle_bnc_mp_erase.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/npcg_toggle_bnc_mp_erase.sv
// Multi-plane block-erase command generator for the Toggle NAND BNC layer.
// One accepted erase command walks 1..MaxPlanes planes of a single way.
// Each plane gets one CAL burst (optional 27h / prefix, 60h, row address,
// optional D1h/D0h confirm) followed by one timer request to the primitive
// manager.
//
// Handshake: a command is accepted only in the cycle where iCMDValid and the
// opcode/target match while oCMDReady is high (Idle). PM requests are held
// until the PM answers: the CAL request waits for iPM_Ready[6:0] all ones,
// the timer request waits for iPM_LastStep[3], and timer expiry is taken from
// iPM_LastStep[0] while waiting.
module npcg_toggle_bnc_mp_erase #(
  parameter int NumberOfWays   = 4,
  parameter int MaxPlanes      = 4,
  parameter int RowAddrCycles  = 3,
  parameter int PlaneBitPos    = 7,
  parameter int InterPlaneWait = 2,
  parameter int FinalWait      = 10
) (
  input  logic                    iSystemClock,
  input  logic                    iReset,
  input  logic [5:0]              iOpcode,
  input  logic [4:0]              iTargetID,
  input  logic [4:0]              iSourceID,
  input  logic                    iCMDValid,
  output logic                    oCMDReady,
  input  logic [NumberOfWays-1:0] iWaySelect,
  input  logic [31:0]             iRowAddress,
  input  logic [3:0]              iPlaneCount,
  output logic                    oStart,
  output logic                    oLastStep,
  input  logic [7:0]              iPM_Ready,
  input  logic [7:0]              iPM_LastStep,
  output logic [7:0]              oPM_PCommand,
  output logic [2:0]              oPM_PCommandOption,
  output logic [NumberOfWays-1:0] oPM_TargetWay,
  output logic [15:0]             oPM_NumOfData,
  output logic                    oPM_CASelect,
  output logic [7:0]              oPM_CAData
);

  localparam int          PW          = (MaxPlanes > 1) ? $clog2(MaxPlanes) : 1;
  // Plane-select field inside the row address; empty for a single-plane build.
  localparam logic [31:0] FIELD_MASK  = (MaxPlanes > 1) ?
                                        (((32'd1 << PW) - 32'd1) << PlaneBitPos) : 32'd0;
  localparam logic [3:0]  NP_MAX_LAST = 4'(MaxPlanes - 1);
  localparam logic [2:0]  ADDR_LAST   = 3'(RowAddrCycles - 1);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_CAL     = 4'd1,
    S_PRESET  = 4'd2,
    S_PREFIX  = 4'd3,
    S_CMD60   = 4'd4,
    S_ADDR    = 4'd5,
    S_CONFIRM = 4'd6,
    S_TM      = 4'd7,
    S_WAIT    = 4'd8
  } state_t;

  state_t                  state, state_next;
  logic [NumberOfWays-1:0] way_q;
  logic [31:0]             row_q;
  logic [3:0]              np_last;
  logic                    opt_dnc, opt_resume, opt_susp;
  logic [3:0]              plane;
  logic [2:0]              addr_cnt;
  logic [7:0]              ca_data;

  logic        trigger;
  logic        is_last;
  logic        is_first;
  logic        commit;
  logic [3:0]  np_last_in;
  logic [31:0] plane_row;
  logic [2:0]  addr_idx_next;
  logic [31:0] row_shift;
  logic [7:0]  ca_next;
  logic [15:0] prefix_bytes;
  logic        unused_bits;

  assign trigger   = iCMDValid & (iTargetID == 5'b00101) & (iOpcode == 6'b000100);
  assign oStart    = trigger;
  assign is_last   = (plane == np_last);
  assign is_first  = (plane == 4'd0);
  assign commit    = ~(is_last & opt_dnc);
  assign plane_row = (row_q & ~FIELD_MASK) | (({28'd0, plane} << PlaneBitPos) & FIELD_MASK);
  assign prefix_bytes = is_first ? (opt_resume ? 16'd2 : 16'd1) : 16'd0;
  assign oPM_TargetWay = way_q;
  assign oPM_CAData    = ca_data;
  assign unused_bits   = &{1'b0, iPM_Ready[7], iPM_LastStep[7:4], iPM_LastStep[2:1],
                           iSourceID[4:3]};

  // Clamp the requested plane count and keep it as the index of the last plane.
  always_comb begin
    np_last_in = 4'd0;
    if (iPlaneCount == 4'd0)
      np_last_in = 4'd0;
    else if ((iPlaneCount - 4'd1) > NP_MAX_LAST)
      np_last_in = NP_MAX_LAST;
    else
      np_last_in = iPlaneCount - 4'd1;
  end

  // Next-state decode and the combinational PM request outputs.
  always_comb begin
    state_next         = state;
    oCMDReady          = 1'b0;
    oPM_PCommand       = 8'h00;
    oPM_PCommandOption = 3'b000;
    oPM_NumOfData      = 16'd0;
    oPM_CASelect       = 1'b0;
    oLastStep          = 1'b0;
    case (state)
      S_IDLE: begin
        oCMDReady = 1'b1;
        if (trigger) state_next = S_CAL;
      end
      S_CAL: begin
        oPM_PCommand  = 8'h08;
        oPM_NumOfData = 16'(1 + RowAddrCycles) + {15'd0, commit} + prefix_bytes;
        if (iPM_Ready[6:0] == 7'h7F) begin
          if (is_first) state_next = opt_resume ? S_PRESET : S_PREFIX;
          else          state_next = S_CMD60;
        end
      end
      S_PRESET: state_next = S_PREFIX;
      S_PREFIX: state_next = S_CMD60;
      S_CMD60:  state_next = S_ADDR;
      S_ADDR: begin
        oPM_CASelect = 1'b1;
        if (addr_cnt == ADDR_LAST) state_next = commit ? S_CONFIRM : S_TM;
      end
      S_CONFIRM: state_next = S_TM;
      S_TM: begin
        oPM_PCommand       = 8'h01;
        oPM_PCommandOption = 3'b110;
        oPM_NumOfData      = is_last ? 16'(FinalWait) : 16'(InterPlaneWait);
        if (iPM_LastStep[3]) state_next = S_WAIT;
      end
      S_WAIT: begin
        if (iPM_LastStep[0]) begin
          oLastStep  = is_last;
          state_next = is_last ? S_IDLE : S_CAL;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // CA byte for the state being entered, so it is registered and valid while
  // that state is current.
  always_comb begin
    addr_idx_next = (state == S_ADDR) ? (addr_cnt + 3'd1) : 3'd0;
    row_shift     = plane_row >> {addr_idx_next, 3'b000};
    ca_next       = 8'h00;
    case (state_next)
      S_PRESET:  ca_next = 8'h27;
      S_PREFIX:  ca_next = opt_susp ? 8'hFA : 8'hA2;
      S_CMD60:   ca_next = 8'h60;
      S_ADDR:    ca_next = row_shift[7:0];
      S_CONFIRM: ca_next = is_last ? 8'hD0 : 8'hD1;
      default:   ca_next = 8'h00;
    endcase
  end

  // State register, command latches, plane/address counters and CA byte.
  always_ff @(posedge iSystemClock or posedge iReset) begin
    if (iReset) begin
      state      <= S_IDLE;
      way_q      <= '0;
      row_q      <= 32'd0;
      np_last    <= 4'd0;
      opt_dnc    <= 1'b0;
      opt_resume <= 1'b0;
      opt_susp   <= 1'b0;
      plane      <= 4'd0;
      addr_cnt   <= 3'd0;
      ca_data    <= 8'h00;
    end else begin
      state   <= state_next;
      ca_data <= ca_next;
      if (state == S_IDLE && trigger) begin
        way_q      <= iWaySelect;
        row_q      <= iRowAddress;
        np_last    <= np_last_in;
        opt_dnc    <= iSourceID[0];
        opt_resume <= iSourceID[1];
        opt_susp   <= iSourceID[2];
        plane      <= 4'd0;
      end else if (state == S_WAIT && iPM_LastStep[0] && !is_last) begin
        plane <= plane + 4'd1;
      end
      if (state == S_ADDR && state_next == S_ADDR)
        addr_cnt <= addr_cnt + 3'd1;
      else
        addr_cnt <= 3'd0;
    end
  end

endmodule

// File: tb/tb_npcg_toggle_bnc_mp_erase.sv
// Bench for the multi-plane erase generator: a PM-side monitor turns the
// DUT's activity into an event stream that is compared against an expected
// queue built from hand-written streams or from a plane-level model.
module tb_npcg_toggle_bnc_mp_erase;

  localparam int NW = 4;
  localparam int EW = 22;
  localparam int EV_CAL = 1, EV_CMD = 2, EV_ADR = 3, EV_TM = 4, EV_LS = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [5:0]    opcode;
  logic [4:0]    target_id;
  logic [4:0]    source_id;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [NW-1:0] way_select;
  logic [31:0]   row_address;
  logic [3:0]    plane_count;
  logic          start;
  logic          last_step;
  logic [7:0]    pm_ready;
  logic [7:0]    pm_last_step;
  logic [7:0]    pm_pcommand;
  logic [2:0]    pm_option;
  logic [NW-1:0] pm_way;
  logic [15:0]   pm_num;
  logic          pm_casel;
  logic [7:0]    pm_cadata;

  npcg_toggle_bnc_mp_erase dut (
    .iSystemClock      (clk),
    .iReset            (rst),
    .iOpcode           (opcode),
    .iTargetID         (target_id),
    .iSourceID         (source_id),
    .iCMDValid         (cmd_valid),
    .oCMDReady         (cmd_ready),
    .iWaySelect        (way_select),
    .iRowAddress       (row_address),
    .iPlaneCount       (plane_count),
    .oStart            (start),
    .oLastStep         (last_step),
    .iPM_Ready         (pm_ready),
    .iPM_LastStep      (pm_last_step),
    .oPM_PCommand      (pm_pcommand),
    .oPM_PCommandOption(pm_option),
    .oPM_TargetWay     (pm_way),
    .oPM_NumOfData     (pm_num),
    .oPM_CASelect      (pm_casel),
    .oPM_CAData        (pm_cadata)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [EW-1:0] ev(input int t, input logic [2:0] o, input logic [15:0] d);
    return {3'(t), o, d};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp_v, $time);
  endtask

  task automatic sb_observe(input logic [EW-1:0] e);
    logic [EW-1:0] x;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL unexpected_event: got %0h, expected none at %0t", e, $time);
    end else begin
      x = exp_q.pop_front();
      chk("event", 32'(e), 32'(x));
    end
  endtask

  // ---------------- reference model ----------------
  // Builds the PM event stream of one command from the plane rules.
  task automatic model_cmd(input logic [3:0] pc, input logic [2:0] src, input logic [31:0] row);
    int np, f;
    bit last, commit;
    logic [31:0] prow;
    np = (pc == 0) ? 1 : (pc > 4) ? 4 : int'(pc);
    for (int p = 0; p < np; p++) begin
      last   = (p == np - 1);
      commit = !(last && src[0]);
      f      = (p == 0) ? (src[1] ? 2 : 1) : 0;
      prow   = row;
      prow[8:7] = 2'(p);
      exp_q.push_back(ev(EV_CAL, 3'd0, 16'(4 + int'(commit) + f)));
      if (p == 0) begin
        if (src[1]) exp_q.push_back(ev(EV_CMD, 3'd0, 16'h27));
        exp_q.push_back(ev(EV_CMD, 3'd0, src[2] ? 16'hFA : 16'hA2));
      end
      exp_q.push_back(ev(EV_CMD, 3'd0, 16'h60));
      for (int b = 0; b < 3; b++)
        exp_q.push_back(ev(EV_ADR, 3'd0, {8'd0, prow[8*b +: 8]}));
      if (commit) exp_q.push_back(ev(EV_CMD, 3'd0, last ? 16'hD0 : 16'hD1));
      exp_q.push_back(ev(EV_TM, 3'b110, last ? 16'd10 : 16'd2));
    end
    exp_q.push_back(ev(EV_LS, 3'd0, 16'd0));
  endtask

  // ---------------- PM-side monitor ----------------
  int            ca_left   = 0;
  int            cal_count = 0;
  int            tm_count  = 0;
  int            ls_count  = 0;
  logic [15:0]   cal_first;
  logic [7:0]    byte_first;
  bit            got_byte;
  logic [NW-1:0] cur_way;

  always @(negedge clk) begin
    if (!rst) begin
      if (ca_left > 0) begin
        sb_observe(ev(pm_casel ? EV_ADR : EV_CMD, 3'd0, {8'd0, pm_cadata}));
        if (!got_byte) begin byte_first = pm_cadata; got_byte = 1'b1; end
        ca_left--;
      end
      if (pm_pcommand == 8'h08 && pm_ready[6:0] == 7'h7F) begin
        sb_observe(ev(EV_CAL, 3'd0, pm_num));
        chk("cal_way", 32'(pm_way), 32'(cur_way));
        if (cal_count == 0) cal_first = pm_num;
        cal_count++;
        ca_left = int'(pm_num);
      end
      if (pm_pcommand == 8'h01 && pm_last_step[3]) begin
        sb_observe(ev(EV_TM, pm_option, pm_num));
        tm_count++;
      end
      if (last_step) begin
        sb_observe(ev(EV_LS, 3'd0, 16'd0));
        chk("ready_at_last", 32'(cmd_ready), 32'd0);
        ls_count++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  int         pm_mode = 0;   // 0: random PM responses, 1: forced values
  logic [7:0] f_ready = 8'hFF;
  logic [7:0] f_ls    = 8'h00;

  task automatic tick();
    @(posedge clk);
    #1;
    if (pm_mode == 0) begin
      pm_ready     = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
      pm_last_step = 8'($urandom);
    end else begin
      pm_ready     = f_ready;
      pm_last_step = f_ls;
    end
  endtask

  task automatic start_cmd(input logic [3:0] pc, input logic [2:0] src, input logic [31:0] row,
                           input logic [NW-1:0] way, input bit use_model);
    cal_count = 0; tm_count = 0; ls_count = 0; got_byte = 1'b0;
    cur_way = way;
    if (use_model) model_cmd(pc, src, row);
    cmd_valid   = 1'b1;
    opcode      = 6'b000100;
    target_id   = 5'b00101;
    source_id   = {2'($urandom), src};
    row_address = row;
    way_select  = way;
    plane_count = pc;
    @(negedge clk);
    chk("start_pulse", 32'(start), 32'd1);
    chk("ready_idle", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid   = 1'b0;
    source_id   = 5'($urandom);
    row_address = $urandom;
    way_select  = NW'($urandom);
    plane_count = 4'($urandom);
  endtask

  task automatic finish_cmd();
    int n;
    n = 0;
    while (ls_count == 0 && n < 4000) begin tick(); n++; end
    if (ls_count == 0) begin
      n_checks++;
      $display("FAIL timeout_last_step: got none, expected pulse at %0t", $time);
    end
    chk("ready_after_last", 32'(cmd_ready), 32'd1);
    tick(); tick();
    chk("last_pulses", 32'(ls_count), 32'd1);
    chk("stream_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic wait_cal(input int target);
    int n;
    n = 0;
    while (cal_count < target && n < 500) begin tick(); n++; end
    if (cal_count < target) begin
      n_checks++;
      $display("FAIL timeout_cal: got %0d, expected %0d", cal_count, target);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0]    pc;
    logic [2:0]    src;
    logic [31:0]   row;
    logic [NW-1:0] way;
    int            planes;
    logic [15:0]   cal0;
    logic [7:0]    b0;
  } vec_t;

  vec_t vecs[8];

  logic [7:0] lo_b[4];
  logic [7:0] mid_b[4];

  initial begin
    vecs[0] = '{4'd1,  3'b000, 32'h0012_3456, 4'b0001, 1, 16'd6, 8'hA2};
    vecs[1] = '{4'd4,  3'b000, 32'h0000_0300, 4'b0010, 4, 16'd6, 8'hA2};
    vecs[2] = '{4'd2,  3'b111, 32'hFFAB_CDEF, 4'b0100, 2, 16'd7, 8'h27};
    vecs[3] = '{4'd0,  3'b000, 32'h0055_AA11, 4'b1000, 1, 16'd6, 8'hA2};
    vecs[4] = '{4'd9,  3'b010, 32'h0001_FF80, 4'b0001, 4, 16'd7, 8'h27};
    vecs[5] = '{4'd3,  3'b100, 32'h0077_0000, 4'b0010, 3, 16'd6, 8'hFA};
    vecs[6] = '{4'd1,  3'b001, 32'h0000_0180, 4'b0100, 1, 16'd5, 8'hA2};
    vecs[7] = '{4'd15, 3'b011, 32'h00C3_3C5A, 4'b1000, 4, 16'd7, 8'h27};
    lo_b  = '{8'h00, 8'h80, 8'h00, 8'h80};
    mid_b = '{8'h02, 8'h02, 8'h03, 8'h03};

    // ---- reset ----
    rst = 1'b1; cmd_valid = 1'b0; opcode = 6'd0; target_id = 5'd0; source_id = 5'd0;
    way_select = '0; row_address = 32'd0; plane_count = 4'd0;
    pm_ready = 8'h00; pm_last_step = 8'h00;
    #1;
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_outputs", {pm_pcommand, pm_cadata, 3'd0, pm_casel, pm_option, 1'b0, pm_way,
                        3'd0, last_step, 1'b0, start}, 32'd0);
    chk("rst_numdata", 32'(pm_num), 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // ---- single plane, explicit stream ----
    pm_mode = 0;
    exp_q.push_back(ev(EV_CAL, 3'd0, 16'd6));
    exp_q.push_back(ev(EV_CMD, 3'd0, 16'hA2));
    exp_q.push_back(ev(EV_CMD, 3'd0, 16'h60));
    exp_q.push_back(ev(EV_ADR, 3'd0, 16'h56));
    exp_q.push_back(ev(EV_ADR, 3'd0, 16'h34));
    exp_q.push_back(ev(EV_ADR, 3'd0, 16'h12));
    exp_q.push_back(ev(EV_CMD, 3'd0, 16'hD0));
    exp_q.push_back(ev(EV_TM, 3'b110, 16'd10));
    exp_q.push_back(ev(EV_LS, 3'd0, 16'd0));
    start_cmd(4'd1, 3'b000, 32'h0012_3456, 4'b0001, 1'b0);
    finish_cmd();

    // ---- four planes, explicit stream with plane field walking ----
    for (int p = 0; p < 4; p++) begin
      exp_q.push_back(ev(EV_CAL, 3'd0, (p == 0) ? 16'd6 : 16'd5));
      if (p == 0) exp_q.push_back(ev(EV_CMD, 3'd0, 16'hA2));
      exp_q.push_back(ev(EV_CMD, 3'd0, 16'h60));
      exp_q.push_back(ev(EV_ADR, 3'd0, {8'd0, lo_b[p]}));
      exp_q.push_back(ev(EV_ADR, 3'd0, {8'd0, mid_b[p]}));
      exp_q.push_back(ev(EV_ADR, 3'd0, 16'h00));
      exp_q.push_back(ev(EV_CMD, 3'd0, (p == 3) ? 16'hD0 : 16'hD1));
      exp_q.push_back(ev(EV_TM, 3'b110, (p == 3) ? 16'd10 : 16'd2));
    end
    exp_q.push_back(ev(EV_LS, 3'd0, 16'd0));
    start_cmd(4'd4, 3'b000, 32'h0000_0300, 4'b0010, 1'b0);
    finish_cmd();

    // ---- table-driven vectors through the model ----
    for (int i = 0; i < 8; i++) begin
      start_cmd(vecs[i].pc, vecs[i].src, vecs[i].row, vecs[i].way, 1'b1);
      finish_cmd();
      chk("vec_planes", 32'(tm_count), 32'(vecs[i].planes));
      chk("vec_cal0", 32'(cal_first), 32'(vecs[i].cal0));
      chk("vec_byte0", 32'(byte_first), 32'(vecs[i].b0));
    end

    // ---- PM not ready: CAL request held ----
    pm_mode = 1; f_ready = 8'h3F; f_ls = 8'h00;
    start_cmd(4'd1, 3'b000, 32'h0024_6801, 4'b0100, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_cal_cmd", 32'(pm_pcommand), 32'h08);
      tick();
    end
    f_ready = 8'hFF;
    tick();
    @(negedge clk);
    chk("stall_release_cmd", 32'(pm_pcommand), 32'h08);
    tick();
    @(negedge clk);
    chk("stall_advanced_cmd", 32'(pm_pcommand), 32'h00);
    chk("stall_advanced_byte", 32'(pm_cadata), 32'hA2);
    pm_mode = 0;
    finish_cmd();

    // ---- retrigger while waiting on the timer ----
    pm_mode = 1; f_ready = 8'hFF; f_ls = 8'h08;
    start_cmd(4'd2, 3'b000, 32'h0013_5700, 4'b0001, 1'b1);
    begin
      int n;
      n = 0;
      while (tm_count < 1 && n < 200) begin tick(); n++; end
    end
    chk("retrig_in_wait", 32'(tm_count), 32'd1);
    tick();
    cmd_valid = 1'b1; opcode = 6'b000100; target_id = 5'b00101;
    way_select = 4'b1000; row_address = 32'h00FF_FFFF; plane_count = 4'd1;
    @(negedge clk);
    chk("retrig_start", 32'(start), 32'd1);
    chk("retrig_busy", 32'(cmd_ready), 32'd0);
    tick();
    cmd_valid = 1'b0;
    pm_mode = 0;
    finish_cmd();
    chk("retrig_planes", 32'(tm_count), 32'd2);

    // ---- asynchronous reset in the middle of plane 2's address ----
    pm_mode = 1; f_ready = 8'hFF; f_ls = 8'h09;
    start_cmd(4'd4, 3'b000, 32'h0042_1100, 4'b0010, 1'b1);
    wait_cal(3);
    tick();
    chk("mid_addr", 32'(pm_casel), 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_ready", 32'(cmd_ready), 32'd1);
    chk("arst_outputs", {pm_pcommand, pm_cadata, 3'd0, pm_casel, pm_option, 1'b0, pm_way,
                         3'd0, last_step, 1'b0, start}, 32'd0);
    chk("arst_numdata", 32'(pm_num), 32'd0);
    exp_q.delete();
    ca_left = 0;
    tick(); tick();
    rst = 1'b0;
    pm_mode = 0;
    tick();
    chk("post_rst_ready", 32'(cmd_ready), 32'd1);

    // ---- randomized commands against the model ----
    for (int i = 0; i < 25; i++) begin
      start_cmd(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), $urandom,
                NW'(1 << $urandom_range(0, NW - 1)), 1'b1);
      finish_cmd();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard stop so a stuck run still reports.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $finish;
  end

endmodule
